// File: rtl/tpu_seq_if.sv
// Host/array-facing signal bundle of the TPU sequencer.
// The slave modport is the sequencer side; master is the host/datapath side.
interface tpu_seq_if #(
    parameter int N  = 2,
    parameter int AW = $clog2(N*N)
);
    logic          ena;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          array_clr;
    logic          array_en;
    logic [AW-1:0] res_sel;
    logic [15:0]   res_data;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;
    logic          busy;
    logic          done;

    modport slave (
        input  ena, in_valid, in_data, res_data, out_ready,
        output in_ready, mem_we, mem_sel, mem_addr, mem_wdata,
               array_clr, array_en, res_sel, out_valid, out_data, busy, done
    );

    modport master (
        output ena, in_valid, in_data, res_data, out_ready,
        input  in_ready, mem_we, mem_sel, mem_addr, mem_wdata,
               array_clr, array_en, res_sel, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/tpu_seq.sv
// Sequencer for the TPU systolic datapath: loads weights and activations,
// clears and steps the array, then drains 16-bit results as byte pairs.
//
// state   | meaning
// IDLE    | waiting for the first weight byte
// LOAD    | writing operand bytes 1 .. 2*N*N-1
// CLEAR   | one-cycle accumulator clear
// COMPUTE | stepping the array 3N-2 times (cnt counts down to 0)
// DRAIN   | streaming result bytes, low byte first
module tpu_seq #(
    parameter int N     = 2,
    parameter int ACC_W = 16
) (
    input logic     clk,
    input logic     rst_n,
    tpu_seq_if.slave bus
);
    localparam int NN = N*N;
    localparam int AW = $clog2(NN);
    localparam int CW = $clog2(2*NN) + 1;
    localparam logic [CW-1:0] LAST_BYTE  = CW'(2*NN - 1);
    localparam logic [CW-1:0] COMPUTE_TC = CW'(3*N - 3);
    localparam logic [CW-1:0] NN_C       = CW'(NN);

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, COMPUTE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          can_load, accept, xfer;

    assign can_load = (state_q == IDLE) || (state_q == LOAD);
    assign accept   = bus.ena & bus.in_valid & can_load;
    assign xfer     = bus.ena & bus.out_ready & (state_q == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = CW'(1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = CLEAR;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            CLEAR: begin
                if (bus.ena) begin
                    cnt_d   = COMPUTE_TC;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (bus.ena) begin
                    if (cnt_q == '0) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.in_ready  = bus.ena & can_load;
        bus.mem_we    = accept;
        bus.mem_wdata = bus.in_data;
        bus.mem_sel   = 1'b0;
        bus.mem_addr  = '0;
        // First N*N bytes are weights, the rest activations
        if (can_load) begin
            if (cnt_q < NN_C) begin
                bus.mem_addr = AW'(cnt_q);
            end else begin
                bus.mem_sel  = 1'b1;
                bus.mem_addr = AW'(cnt_q - NN_C);
            end
        end
        bus.array_clr = bus.ena & (state_q == CLEAR);
        bus.array_en  = bus.ena & (state_q == COMPUTE);
        bus.out_valid = bus.ena & (state_q == DRAIN);
        bus.res_sel   = (state_q == DRAIN) ? AW'(cnt_q >> 1) : '0;
        bus.out_data  = cnt_q[0] ? bus.res_data[ACC_W-1 -: 8] : bus.res_data[7:0];
        bus.busy      = (state_q != IDLE);
        bus.done      = done_q;
    end
endmodule

// File: tb/tb_tpu_seq.sv
// Scoreboard bench for tpu_seq (N=2): expected writes and output bytes are
// queued by the stimulus and popped by a negedge monitor.
module tb_tpu_seq;
    localparam int N  = 2;
    localparam int NN = N*N;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tpu_seq_if #(.N(N)) bus();
    tpu_seq #(.N(N), .ACC_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Array model: result of PE i is 16'h1234 + i
    assign bus.res_data = 16'h1234 + 16'(bus.res_sel);

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] wr_q[$];
    logic [7:0]  out_q[$];

    int   en_total = 0, clr_total = 0, done_total = 0;
    int   en_after_clr = 0, valid_after_en = 0, streak = 0, last_streak = 0;
    logic prev_clr = 1'b0, prev_en = 1'b0, prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [10:0] ew;
        logic [7:0]  eb;
        if (!rst_n) begin
            prev_clr = 1'b0; prev_en = 1'b0; prev_valid = 1'b0; streak = 0;
        end else begin
            if (bus.mem_we) begin
                if (wr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_write: got sel=%0d addr=%0d data=%0h expected no write",
                             bus.mem_sel, bus.mem_addr, bus.mem_wdata);
                end else begin
                    ew = wr_q.pop_front();
                    chk("write", {21'b0, bus.mem_sel, bus.mem_addr, bus.mem_wdata}, {21'b0, ew});
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (out_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_out: got %0h expected no transfer", bus.out_data);
                end else begin
                    eb = out_q.pop_front();
                    chk("out_byte", {24'b0, bus.out_data}, {24'b0, eb});
                end
            end
            if (!bus.ena)
                chk("frozen_strobes", {27'b0, bus.mem_we, bus.array_en, bus.array_clr,
                                       bus.out_valid, bus.in_ready}, 32'd0);
            if (bus.array_clr) clr_total++;
            if (bus.array_en) begin
                en_total++;
                streak++;
                if (prev_clr) en_after_clr++;
            end else if (bus.ena) begin
                if (prev_en) last_streak = streak;
                streak = 0;
            end
            if (bus.out_valid && !prev_valid && prev_en) valid_after_en++;
            if (bus.done) done_total++;
            prev_clr   = bus.array_clr;
            prev_valid = bus.out_valid;
            if (bus.ena) prev_en = bus.array_en;
        end
    end

    task automatic send(input logic [7:0] b, input int k);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        wr_q.push_back({(k >= NN) ? 1'b1 : 1'b0, AW'(k % NN), b});
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [7:0] v[8], input int freeze_at);
        for (int k = 0; k < 2*NN; k++) begin
            if (k == freeze_at) begin
                bus.ena = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hAA;
                repeat (3) @(posedge clk);
                #1 bus.ena = 1'b1;
            end
            send(v[k], k);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        chk("in_ready_after_load", {31'b0, bus.in_ready}, 32'd0);
    endtask

    task automatic wait_drain(input bit compute_freeze);
        int en_base  = en_total;
        int clr_base = clr_total;
        bit frozen   = 0;
        for (int i = 0; i < 100 && !bus.out_valid; i++) begin
            if (compute_freeze && !frozen && (en_total - en_base) >= 2) begin
                bus.ena = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.ena = 1'b1;
                frozen = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b0;
        chk("out_valid_reached", {31'b0, bus.out_valid}, 32'd1);
        chk("clr_cycles", 32'(clr_total - clr_base), 32'd1);
        chk("en_cycles", 32'(en_total - en_base), 32'd4);
        for (int i = 0; i < 2*NN; i++)
            out_q.push_back((i % 2 == 1) ? 8'h12 : 8'(8'h34 + i/2));
    endtask

    task automatic drain(input bit toggle);
        int d_base = done_total;
        for (int i = 0; i < 200 && done_total == d_base; i++) begin
            bus.out_ready = toggle ? (i % 2 == 0) : 1'b1;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        chk("done_pulses", 32'(done_total - d_base), 32'd1);
        chk("idle_after_drain", {30'b0, bus.busy, bus.in_ready}, 32'd1);
        chk("out_queue_empty", 32'(out_q.size()), 32'd0);
        chk("write_queue_empty", 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] v1[8] = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd5, 8'd6, 8'd7, 8'd8};
        logic [7:0] v2[8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        logic [7:0] v3[8] = '{8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
        int base;

        bus.ena = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes", {25'b0, bus.busy, bus.out_valid, bus.mem_we, bus.array_clr,
                              bus.array_en, bus.done, bus.mem_sel}, 32'd0);
        chk("reset_addr", {28'b0, bus.mem_addr, bus.res_sel}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", {31'b0, bus.in_ready}, 32'd1);

        // Run 1: back-to-back load, toggled backpressure on drain
        load(v1, -1);
        wait_drain(1'b0);
        drain(1'b1);
        chk("en_contiguous", 32'(last_streak), 32'd4);
        chk("en_follows_clr", 32'(en_after_clr), 32'd1);
        chk("valid_follows_en", 32'(valid_after_en), 32'd1);

        // Run 2: ena dropped mid-LOAD and mid-COMPUTE
        load(v2, 3);
        wait_drain(1'b1);
        drain(1'b0);

        // Run 3: reset during COMPUTE
        load(v3, -1);
        base = en_total;
        for (int i = 0; i < 50 && en_total == base; i++) begin
            @(posedge clk); #1;
        end
        chk("compute_started", {31'b0, bus.array_en}, 32'd1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_compute", {29'b0, bus.array_en, bus.busy, bus.out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Run 4: fresh load must restart at weight address 0
        load(v3, -1);
        wait_drain(1'b0);
        drain(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
